async_collect_block: RTL and testbench



---
 rtl/async_collect_block.sv | 147 ++++++++++++++
 tb/tb_async_collect_block.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/async_collect_block.sv
// rtl/async_collect_block.sv - serial word stream to parallel frame collector
//
// Captures one data_width-bit word per clock while freeze_l is low, and after
// weight_n words publishes the whole frame on data_out with a go handshake.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   freeze_l    - low: data_in carries a valid word this cycle
//   data_in     - serial word
//   go_in_r     - downstream acknowledge (sampled in HOLD only)
//   err_clr     - synchronous clear of the sticky error flags
//   data_out    - published frame, word i at [data_width*i +: data_width]
//   go_out_r    - frame valid to downstream
//   go_out_l    - ready to upstream, a new frame may start
//   err_short   - sticky: stream ended before a full frame
//   err_over    - sticky: word offered while not accepting
module async_collect_block #(
  parameter int weight_n   = 5,
  parameter int data_width = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           freeze_l,
  input  logic [data_width-1:0]          data_in,
  input  logic                           go_in_r,
  input  logic                           err_clr,
  output logic [data_width*weight_n-1:0] data_out,
  output logic                           go_out_r,
  output logic                           go_out_l,
  output logic                           err_short,
  output logic                           err_over
);

  localparam int addr_w = (weight_n > 1) ? $clog2(weight_n) : 1;
  localparam logic [addr_w-1:0] last_addr = addr_w'(weight_n - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [addr_w-1:0]              addr_q, addr_d;
  logic [data_width-1:0]          shadow_q [weight_n];
  logic [data_width-1:0]          shadow_d [weight_n];
  logic [data_width*weight_n-1:0] data_out_q, data_out_d;
  logic [data_width*weight_n-1:0] frame;
  logic                           err_short_q, err_short_d;
  logic                           err_over_q, err_over_d;

  // Frame as it would be published this cycle: the last word bypasses the
  // shadow buffer so publish happens on the same edge as the last capture.
  always_comb begin
    frame = '0;
    for (int i = 0; i < weight_n - 1; i++) begin
      frame[i*data_width +: data_width] = shadow_q[i];
    end
    frame[(weight_n-1)*data_width +: data_width] = data_in;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    shadow_d   = shadow_q;
    data_out_d = data_out_q;
    // Clear first, then set conditions OR in so a set wins over err_clr.
    err_short_d = err_short_q & ~err_clr;
    err_over_d  = err_over_q & ~err_clr;

    unique case (state_q)
      IDLE: begin
        if (!freeze_l) begin
          shadow_d[0] = data_in;
          if (weight_n == 1) begin
            data_out_d = frame;
            state_d    = HOLD;
          end else begin
            addr_d  = addr_w'(1);
            state_d = COLLECT;
          end
        end
      end

      COLLECT: begin
        if (!freeze_l) begin
          shadow_d[addr_q] = data_in;
          if (addr_q == last_addr) begin
            data_out_d = frame;
            addr_d     = '0;
            state_d    = HOLD;
          end else begin
            addr_d = addr_q + addr_w'(1);
          end
        end else begin
          // Partial frame is abandoned; data_out keeps the previous frame.
          err_short_d = 1'b1;
          addr_d      = '0;
          state_d     = IDLE;
        end
      end

      HOLD: begin
        if (go_in_r) begin
          state_d = IDLE;
        end
        if (!freeze_l) begin
          err_over_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_out_q  <= '0;
      err_short_q <= 1'b0;
      err_over_q  <= 1'b0;
      for (int i = 0; i < weight_n; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      err_short_q <= err_short_d;
      err_over_q  <= err_over_d;
      for (int i = 0; i < weight_n; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign data_out  = data_out_q;
  assign go_out_r  = (state_q == HOLD);
  assign go_out_l  = (state_q == IDLE);
  assign err_short = err_short_q;
  assign err_over  = err_over_q;

endmodule

// File: tb/tb_async_collect_block.sv
// tb/tb_async_collect_block.sv - testbench for async_collect_block (weight_n 5 and 1)
module tb_async_collect_block;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze_l = 1'b1;
  logic [15:0] data_in = '0;
  logic        go_in_r = 1'b0;
  logic        err_clr = 1'b0;

  logic [79:0] d5_data_out;
  logic        d5_go_out_r, d5_go_out_l, d5_err_short, d5_err_over;
  logic [15:0] d1_data_out;
  logic        d1_go_out_r, d1_go_out_l, d1_err_short, d1_err_over;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  async_collect_block #(.weight_n(5), .data_width(16)) dut5 (
    .clk(clk), .rst_n(rst_n), .freeze_l(freeze_l), .data_in(data_in),
    .go_in_r(go_in_r), .err_clr(err_clr), .data_out(d5_data_out),
    .go_out_r(d5_go_out_r), .go_out_l(d5_go_out_l),
    .err_short(d5_err_short), .err_over(d5_err_over)
  );

  async_collect_block #(.weight_n(1), .data_width(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .freeze_l(freeze_l), .data_in(data_in),
    .go_in_r(go_in_r), .err_clr(err_clr), .data_out(d1_data_out),
    .go_out_r(d1_go_out_r), .go_out_l(d1_go_out_l),
    .err_short(d1_err_short), .err_over(d1_err_over)
  );

  // Behavioural model: index 0 models weight_n=5, index 1 models weight_n=1.
  logic [15:0] mw [2][8];
  int          mcnt  [2];
  bit          mhold [2];
  logic [79:0] mdout [2];
  bit          mshort[2];
  bit          mover [2];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0; mhold[m] = 0; mdout[m] = '0; mshort[m] = 0; mover[m] = 0;
    end
  endtask

  task automatic model_step(input int m, input int n);
    bit s_set = 0;
    bit o_set = 0;
    if (mhold[m]) begin
      if (!freeze_l) o_set = 1;
      if (go_in_r) mhold[m] = 0;
    end else if (!freeze_l) begin
      mw[m][mcnt[m]] = data_in;
      mcnt[m]++;
      if (mcnt[m] == n) begin
        mdout[m] = '0;
        for (int i = 0; i < n; i++) mdout[m][16*i +: 16] = mw[m][i];
        mhold[m] = 1;
        mcnt[m]  = 0;
      end
    end else if (mcnt[m] > 0) begin
      s_set   = 1;
      mcnt[m] = 0;
    end
    mshort[m] = s_set | (mshort[m] & !err_clr);
    mover[m]  = o_set | (mover[m] & !err_clr);
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic drive(input logic fl, input logic [15:0] din, input logic gi, input logic ec);
    freeze_l = fl; data_in = din; go_in_r = gi; err_clr = ec;
    @(posedge clk);
    if (rst_n) begin
      model_step(0, 5);
      model_step(1, 1);
    end
    #1;
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("d5_data_out", d5_data_out, mdout[0]);
    check("d5_go_out_r", {79'b0, d5_go_out_r}, {79'b0, mhold[0]});
    check("d5_go_out_l", {79'b0, d5_go_out_l}, {79'b0, (!mhold[0] && mcnt[0] == 0)});
    check("d5_err_short", {79'b0, d5_err_short}, {79'b0, mshort[0]});
    check("d5_err_over", {79'b0, d5_err_over}, {79'b0, mover[0]});
    check("d1_data_out", {64'b0, d1_data_out}, mdout[1]);
    check("d1_go_out_r", {79'b0, d1_go_out_r}, {79'b0, mhold[1]});
    check("d1_go_out_l", {79'b0, d1_go_out_l}, {79'b0, (!mhold[1] && mcnt[1] == 0)});
    check("d1_err_short", {79'b0, d1_err_short}, {79'b0, mshort[1]});
    check("d1_err_over", {79'b0, d1_err_over}, {79'b0, mover[1]});
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_data_out"}, d5_data_out, 80'h0);
    check({tag, "_go_out_r"}, {79'b0, d5_go_out_r}, 80'h0);
    check({tag, "_go_out_l"}, {79'b0, d5_go_out_l}, 80'h1);
    check({tag, "_err_short"}, {79'b0, d5_err_short}, 80'h0);
    check({tag, "_err_over"}, {79'b0, d5_err_over}, 80'h0);
    check({tag, "_d1_data_out"}, {64'b0, d1_data_out}, 80'h0);
  endtask

  logic [15:0] words_a [5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    drive(1, 16'h0, 0, 0);

    // Basic frame
    for (int i = 0; i < 5; i++) begin
      drive(0, words_a[i], 0, 0);
      check("basic_go_out_l", {79'b0, d5_go_out_l}, 80'h0);
      if (i < 4) check("basic_go_out_r_low", {79'b0, d5_go_out_r}, 80'h0);
    end
    check("basic_data_out", d5_data_out, 80'h0055_0044_0033_0022_0011);
    check("basic_go_out_r", {79'b0, d5_go_out_r}, 80'h1);

    // Handshake: hold for 10 cycles then acknowledge
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'hDEAD, 0, 0);
      check("hold_go_out_r", {79'b0, d5_go_out_r}, 80'h1);
      check("hold_data_out", d5_data_out, 80'h0055_0044_0033_0022_0011);
    end
    drive(1, 16'h0, 1, 0);
    check("ack_go_out_r", {79'b0, d5_go_out_r}, 80'h0);
    check("ack_go_out_l", {79'b0, d5_go_out_l}, 80'h1);
    drive(1, 16'h0, 0, 1);

    // Short frame after 3 words
    drive(0, 16'h00A1, 0, 0);
    drive(0, 16'h00A2, 0, 0);
    drive(0, 16'h00A3, 0, 0);
    drive(1, 16'h0, 0, 0);
    check("short_err_short", {79'b0, d5_err_short}, 80'h1);
    check("short_go_out_l", {79'b0, d5_go_out_l}, 80'h1);
    check("short_data_out", d5_data_out, 80'h0055_0044_0033_0022_0011);
    drive(1, 16'h0, 0, 1);
    check("short_clr", {79'b0, d5_err_short}, 80'h0);

    // Short frame coinciding with err_clr: set wins
    drive(0, 16'h00C7, 0, 0);
    drive(0, 16'h00C8, 0, 0);
    drive(1, 16'h0, 0, 1);
    check("short_set_wins", {79'b0, d5_err_short}, 80'h1);
    drive(1, 16'h0, 0, 1);
    check("short_clr2", {79'b0, d5_err_short}, 80'h0);

    // Overrun: 7 words with go_in_r low
    for (int i = 1; i <= 7; i++) begin
      drive(0, 16'(16'h00B0 + i), 0, 0);
      if (i == 5) check("over_go_out_r", {79'b0, d5_go_out_r}, 80'h1);
    end
    check("over_err_over", {79'b0, d5_err_over}, 80'h1);
    check("over_data_out", d5_data_out, 80'h00B5_00B4_00B3_00B2_00B1);
    // Acknowledge and overrun in the same cycle
    drive(0, 16'h00BF, 1, 0);
    check("over_ack_go_out_l", {79'b0, d5_go_out_l}, 80'h1);
    drive(1, 16'h0, 1, 1);
    check("over_clr", {79'b0, d5_err_over}, 80'h0);

    // Back-to-back with go_in_r tied high
    for (int i = 1; i <= 5; i++) drive(0, 16'(16'h00C0 + i), 1, 0);
    check("b2b_first", d5_data_out, 80'h00C5_00C4_00C3_00C2_00C1);
    check("b2b_first_go", {79'b0, d5_go_out_r}, 80'h1);
    drive(1, 16'h0, 1, 0);
    check("b2b_first_pulse", {79'b0, d5_go_out_r}, 80'h0);
    for (int i = 1; i <= 5; i++) drive(0, 16'(16'h00D0 + i), 1, 0);
    check("b2b_second", d5_data_out, 80'h00D5_00D4_00D3_00D2_00D1);
    check("b2b_second_go", {79'b0, d5_go_out_r}, 80'h1);
    drive(1, 16'h0, 1, 0);
    check("b2b_second_pulse", {79'b0, d5_go_out_r}, 80'h0);

    // Reset mid-frame
    drive(0, 16'h00E1, 1, 0);
    drive(0, 16'h00E2, 1, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals("midreset");
    freeze_l = 1'b1;
    go_in_r  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 16'h0, 0, 0);

    // Degenerate weight_n=1 frame
    drive(0, 16'hBEEF, 0, 0);
    check("degen_data_out", {64'b0, d1_data_out}, 80'hBEEF);
    check("degen_go_out_r", {79'b0, d1_go_out_r}, 80'h1);
    drive(1, 16'h0, 1, 0);
    check("degen_ack", {79'b0, d1_go_out_r}, 80'h0);
    drive(1, 16'h0, 0, 1);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
